// File: rtl/fetch_unit.sv
// fetch_unit -- rv32i instruction fetch stage.
//
// Holds the PC and issues sequential word fetches to instruction memory.
// Returned words go into a small in-order FIFO that feeds decode over a
// valid/ready handshake. The opcode, funct3 and funct7[5] fields are sliced
// out for control_unit. A taken branch redirects the PC, empties the FIFO
// and marks every request still in flight as stale.
//
// Ports:
//   clk_i, arst_ni                    clock, async active-low reset
//   imem_req_valid_o/ready_i/addr_o   fetch request channel
//   imem_rsp_valid_i/data_i           in-order response, cannot stall
//   branch_taken_i/branch_target_i    redirect from execute
//   instr_valid_o/ready_i             decode handshake
//   instr_o, pc_o                     FIFO head word and its PC
//   instr_type_o, func_code_o,
//   funct7b5_o                        pre-sliced decode fields
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [31:0]       imem_rsp_data_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [6:0]        instr_type_o,
  output logic [2:0]        func_code_o,
  output logic              funct7b5_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]             pc;
  logic [CW-1:0]                 outstanding, drop_cnt, fifo_cnt;
  logic [DEPTH-1:0][31:0]        fifo_instr, fifo_instr_n;
  logic [DEPTH-1:0][ADDR_W-1:0]  fifo_pc, fifo_pc_n;
  logic [DEPTH-1:0][ADDR_W-1:0]  ifq_pc, ifq_pc_n;  // PCs of in-flight requests

  logic          rsp_ok, accept, push, pop;
  logic [CW:0]   occ;
  logic [CW-1:0] out_next, fifo_wr, ifq_wr;

  // Target bits [1:0] are forced to zero; they are intentionally unused.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  // A response with nothing outstanding is a protocol violation: ignore it.
  assign rsp_ok = imem_rsp_valid_i && (outstanding != '0);
  assign pop    = instr_valid_o && instr_ready_i;
  assign push   = rsp_ok && (drop_cnt == '0) && !branch_taken_i;

  // Occupancy gives credit for a pop at this edge so DEPTH=2 with 1-cycle
  // memory sustains one instruction per cycle. outstanding + fifo_cnt never
  // exceeds DEPTH, so a returning response always finds a free FIFO slot.
  assign occ = (CW+1)'(outstanding) + (CW+1)'(fifo_cnt) - (CW+1)'(pop);

  // Gating with arst_ni keeps the request low while reset is held and lets
  // it rise in the first cycle after release.
  assign imem_req_valid_o = arst_ni && (occ < (CW+1)'(DEPTH));
  assign imem_req_addr_o  = pc;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  assign out_next = outstanding + CW'(accept) - CW'(rsp_ok);
  assign fifo_wr  = fifo_cnt - CW'(pop);
  assign ifq_wr   = outstanding - CW'(rsp_ok);

  // Both queues are shift registers with the head at index 0: a pop shifts
  // down, and a push lands just above the surviving entries.
  always_comb begin
    ifq_pc_n     = ifq_pc;
    fifo_instr_n = fifo_instr;
    fifo_pc_n    = fifo_pc;
    if (rsp_ok)
      for (int i = 0; i < DEPTH - 1; i++) ifq_pc_n[i] = ifq_pc[i+1];
    if (accept)
      for (int i = 0; i < DEPTH; i++)
        if (ifq_wr == CW'(i)) ifq_pc_n[i] = pc;
    if (pop)
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_instr_n[i] = fifo_instr[i+1];
        fifo_pc_n[i]    = fifo_pc[i+1];
      end
    if (push)
      for (int i = 0; i < DEPTH; i++)
        if (fifo_wr == CW'(i)) begin
          fifo_instr_n[i] = imem_rsp_data_i;
          fifo_pc_n[i]    = ifq_pc[0];
        end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_cnt    <= '0;
      ifq_pc      <= '0;
      fifo_instr  <= '0;
      fifo_pc     <= '0;
    end else begin
      outstanding <= out_next;
      ifq_pc      <= ifq_pc_n;
      fifo_instr  <= fifo_instr_n;
      fifo_pc     <= fifo_pc_n;
      if (branch_taken_i) begin
        // Everything in flight after this edge is stale; the in-flight PC
        // queue keeps tracking them so it stays aligned with drop_cnt.
        pc       <= {branch_target_i[ADDR_W-1:2], 2'b00};
        drop_cnt <= out_next;
        fifo_cnt <= '0;
      end else begin
        if (accept) pc <= pc + ADDR_W'(4);
        if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  assign instr_valid_o = (fifo_cnt != '0);
  assign instr_o       = fifo_instr[0];
  assign pc_o          = fifo_pc[0];
  assign instr_type_o  = instr_o[6:0];
  assign func_code_o   = instr_o[14:12];
  assign funct7b5_o    = instr_o[30];
endmodule
